alu_seq_muldiv: RTL

//  Parametrised successor to the single-cycle ALU for the MIPS-lite datapath: same-cycle logic/arith ops plus an

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_muldiv_iter.sv | 179 +++++++++++++++++
 rtl/alu_seq_muldiv.sv | 77 +++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the MIPS-lite ALU: gin opcodes, mul/div FSM states, opcode helpers.
// The divide ops are only implemented when ALU_DIV_EN is defined.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_MFHI  = 4'b1100;
  localparam logic [3:0] OP_MFLO  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } md_state_e;

  function automatic logic is_seq_op(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return op[3:1] == 3'b101;
  endfunction

  // MULT and DIV are the even codes of the sequential group.
  function automatic logic is_signed_op(input logic [3:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide unit: shift-add multiplier, restoring divider, HI/LO registers.
// The divider datapath exists only when ALU_DIV_EN is defined.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  input  logic             start_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output md_state_e        state_o,
  output logic             done_o,
  output logic             div_zero_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int W2    = 2 * WIDTH;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    work_q, work_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_q, neg_d;
  logic             done_q, done_d;

  logic             signed_op;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next, prod_fix;

  assign signed_op = is_signed_op(op_i);
  assign mag_a     = (signed_op && a_i[WIDTH-1]) ? -a_i : a_i;
  assign mag_b     = (signed_op && b_i[WIDTH-1]) ? -b_i : b_i;
  assign last      = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef ALU_DIV_EN
  assign accept = start_i && is_seq_op(op_i) && (state_q == IDLE);
`else
  assign accept = start_i && is_seq_op(op_i) && !is_div_op(op_i) && (state_q == IDLE);
`endif

  // work_q low half holds the multiplier and shifts right; partial product accumulates on top.
  assign mul_sum  = {1'b0, work_q[W2-1:WIDTH]} + (work_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, work_q[WIDTH-1:1]};
  assign prod_fix = neg_q ? -mul_next : mul_next;

`ifdef ALU_DIV_EN
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH:0]   div_trial;
  logic [W2-1:0]    div_next;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Remainder on top, dividend shifting out of the low half as quotient bits shift in.
  assign div_trial = work_q[W2-1:WIDTH-1] - {1'b0, opb_q};
  assign div_next  = div_trial[WIDTH] ? {work_q[W2-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
  assign quo_fix   = neg_q  ? -div_next[WIDTH-1:0]  : div_next[WIDTH-1:0];
  assign rem_fix   = rneg_q ? -div_next[W2-1:WIDTH] : div_next[W2-1:WIDTH];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef ALU_DIV_EN
    rneg_d     = rneg_q;
    dz_d       = dz_q;
    a_d        = a_q;
    div_zero_d = div_zero_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = is_div_op(op_i) ? DIV : MUL;
          cnt_d   = '0;
          work_d  = {{WIDTH{1'b0}}, mag_a};
          opb_d   = mag_b;
          neg_d   = signed_op && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
`ifdef ALU_DIV_EN
          rneg_d     = signed_op && a_i[WIDTH-1];
          dz_d       = (b_i == '0);
          a_d        = a_i;
          div_zero_d = 1'b0;
`endif
        end
      end
      MUL: begin
        work_d = mul_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last) begin
          hi_d    = prod_fix[W2-1:WIDTH];
          lo_d    = prod_fix[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      DIV: begin
`ifdef ALU_DIV_EN
        work_d = div_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last) begin
          hi_d       = dz_q ? a_q : rem_fix;
          lo_d       = dz_q ? {WIDTH{1'b1}} : quo_fix;
          div_zero_d = dz_q;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

`ifdef ALU_DIV_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      a_q        <= '0;
      div_zero_q <= 1'b0;
    end else begin
      rneg_q     <= rneg_d;
      dz_q       <= dz_d;
      a_q        <= a_d;
      div_zero_q <= div_zero_d;
    end
  end
  assign div_zero_o = div_zero_q;
`else
  assign div_zero_o = 1'b0;
`endif

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign state_o = state_q;
  assign done_o  = done_q;

endmodule

// File: rtl/alu_seq_muldiv.sv
// MIPS-lite EX-stage ALU: single-cycle logic/arith ops plus iterative MULT/DIV with HI/LO.
// Define ALU_DIV_EN to build the divider; without it DIV/DIVU decode as illegal.
module alu_seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       gin,
  input  logic             start,
  output logic [WIDTH-1:0] sum,
  output logic             zout,
  output logic             vout,
  output logic             illegal,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  logic [WIDTH-1:0] hi_w, lo_w;
  logic [WIDTH-1:0] add_res, sub_res;
  logic             add_ovf, sub_ovf;
  md_state_e        md_state;

  alu_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk_i      (clk),
    .rst_i      (reset),
    .a_i        (a),
    .b_i        (b),
    .op_i       (gin),
    .start_i    (start),
    .hi_o       (hi_w),
    .lo_o       (lo_w),
    .state_o    (md_state),
    .done_o     (done),
    .div_zero_o (div_zero)
  );

  assign busy    = (md_state != IDLE);
  assign add_res = a + b;
  assign sub_res = a - b;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    sum     = '0;
    vout    = 1'b0;
    illegal = 1'b0;
    case (gin)
      OP_AND:  sum = a & b;
      OP_OR:   sum = a | b;
      OP_ADD:  begin sum = add_res; vout = add_ovf; end
      OP_XOR:  sum = a ^ b;
      OP_NOR:  sum = ~(a | b);
      OP_SLTU: sum = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SUB:  begin sum = sub_res; vout = sub_ovf; end
      OP_SLT:  sum = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MULT, OP_MULTU: sum = '0;
`ifdef ALU_DIV_EN
      OP_DIV, OP_DIVU:   sum = '0;
`else
      OP_DIV, OP_DIVU:   illegal = 1'b1;
`endif
      OP_MFHI: sum = hi_w;
      OP_MFLO: sum = lo_w;
      default: illegal = 1'b1;
    endcase
  end

  assign zout = ~|sum;

endmodule
